// File: rtl/crp16_clock_ctrl_pkg.sv
// crp16_clock_ctrl_pkg: mode and FSM state encodings shared by the CRP16 clock controller.
package crp16_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CC_IDLE  = 2'b00,
        CC_PH_HI = 2'b01,
        CC_PH_LO = 2'b10
    } state_e;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser, stability counter and rising-edge pulse for a raw push-button.
module button_debouncer #(
    parameter int DEBOUNCE = 500000
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic btn_i,
    output logic evt_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          evt_q, evt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire;

    // The level flips on the DEBOUNCE-th consecutive cycle of disagreement.
    assign expire = cnt_q == CW'(DEBOUNCE - 1);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        evt_d   = 1'b0;
        if (sync_q[1] != level_q) begin
            cnt_d   = expire ? '0 : cnt_q + 1'b1;
            level_d = expire ? sync_q[1] : level_q;
            evt_d   = expire & sync_q[1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/crp16_clock_ctrl.sv
// crp16_clock_ctrl: processor clock generator with halt/run/step/burst modes, four rates and an edge counter.
module crp16_clock_ctrl
    import crp16_clock_ctrl_pkg::*;
#(
    parameter int RATE0    = 12499999,
    parameter int RATE1    = 1249999,
    parameter int RATE2    = 24999,
    parameter int RATE3    = 0,
    parameter int CNT_W    = 32,
    parameter int DEBOUNCE = 500000
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic [1:0]  mode_i,
    input  logic [1:0]  rate_sel_i,
    input  logic        step_req_i,
    input  logic [7:0]  burst_len_i,
    output logic        cpu_clock_o,
    output logic        cpu_tick_o,
    output logic        busy_o,
    output logic [15:0] edge_count_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, rate;
    logic [7:0]       rem_q, rem_d;
    logic             clk_q, clk_d, tick_q, tick_d, busy_q, busy_d;
    logic [15:0]      edge_count_q, edge_d;
    logic             step_evt, start, again, enter;
    mode_e            mode;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .btn_i    (step_req_i),
        .evt_o    (step_evt)
    );

    assign mode  = mode_e'(mode_i);
    assign rate  = rate_sel_i == 2'd0 ? CNT_W'(RATE0) :
                   rate_sel_i == 2'd1 ? CNT_W'(RATE1) :
                   rate_sel_i == 2'd2 ? CNT_W'(RATE2) : CNT_W'(RATE3);
    assign start = mode == MODE_RUN ||
                   (step_evt && (mode == MODE_STEP || (mode == MODE_BURST && burst_len_i != 8'd0)));
    assign again = mode == MODE_RUN || (mode == MODE_BURST && rem_q != 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = state_q == CC_IDLE ? cnt_q : cnt_q - 1'b1;
        rem_d   = rem_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        busy_d  = busy_q;
        edge_d  = edge_count_q;
        enter   = 1'b0;
        case (state_q)
            CC_IDLE: begin
                enter = start;
                rem_d = mode == MODE_BURST ? burst_len_i - 8'd1 : 8'd0;
            end
            CC_PH_HI: if (cnt_q == '0) begin
                state_d = CC_PH_LO;
                clk_d   = 1'b0;
                cnt_d   = rate;
            end
            CC_PH_LO: if (cnt_q == '0) begin
                enter   = again;
                rem_d   = mode == MODE_BURST ? rem_q - 8'd1 : rem_q;
                state_d = CC_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = CC_IDLE;
        endcase
        // Every PH_HI entry, from IDLE or back-to-back from PH_LO, shares this path.
        if (enter) begin
            state_d = CC_PH_HI;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
            busy_d  = 1'b1;
            edge_d  = edge_count_q + 16'd1;
            cnt_d   = rate;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= CC_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            clk_q        <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            clk_q        <= clk_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            edge_count_q <= edge_d;
        end
    end

    assign cpu_clock_o  = clk_q;
    assign cpu_tick_o   = tick_q;
    assign busy_o       = busy_q;
    assign edge_count_o = edge_count_q;

endmodule

// File: tb/tb_crp16_clock_ctrl.sv
// tb_crp16_clock_ctrl: directed and randomized checks of the clock controller against a waveform-queue model.
module tb_crp16_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  rate_sel = 2'b00;
    logic        step_req = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic        cpu_clock, cpu_tick, busy;
    logic [15:0] edge_count;

    int          checks = 0;
    int          failures = 0;
    bit          exp_q[$];
    bit          prev_hi = 1'b0;
    logic [15:0] model_edges = 16'd0;
    int          req_left = 0;

    always #5 clk = ~clk;

    crp16_clock_ctrl #(
        .RATE0(3), .RATE1(1), .RATE2(0), .RATE3(0), .CNT_W(32), .DEBOUNCE(4)
    ) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .mode_i       (mode),
        .rate_sel_i   (rate_sel),
        .step_req_i   (step_req),
        .burst_len_i  (burst_len),
        .cpu_clock_o  (cpu_clock),
        .cpu_tick_o   (cpu_tick),
        .busy_o       (busy),
        .edge_count_o (edge_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Phase length in clock cycles is RATE+1 with the bench rates 3,1,0,0.
    function automatic int plen(input logic [1:0] s);
        return s == 2'd0 ? 4 : s == 2'd1 ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_period(input int hi, input int lo);
        repeat (hi) exp_q.push_back(1'b1);
        repeat (lo) exp_q.push_back(1'b0);
    endtask

    task automatic step();
        @(negedge clk);
        if (req_left > 0) begin
            req_left--;
            if (req_left == 0) step_req = 1'b0;
        end
    endtask

    task automatic cmp_now(input string tag);
        bit hi = 1'b0;
        bit act = 1'b0;
        bit rise;
        if (exp_q.size() > 0) begin
            hi  = exp_q.pop_front();
            act = 1'b1;
        end
        rise = hi && !prev_hi;
        if (rise) model_edges = model_edges + 16'd1;
        chk({tag, ".clk"},   16'(cpu_clock), 16'(hi));
        chk({tag, ".tick"},  16'(cpu_tick),  16'(rise));
        chk({tag, ".busy"},  16'(busy),      16'(act));
        chk({tag, ".edges"}, edge_count,     model_edges);
        prev_hi = hi;
    endtask

    task automatic play(input int n, input string tag);
        repeat (n) begin
            step();
            cmp_now(tag);
        end
    endtask

    task automatic press(input int len);
        step_req = 1'b1;
        req_left = len;
    endtask

    task automatic wait_rise(input string tag, input int lo, input int hi);
        int lat = 0;
        bit seen = 1'b0;
        while (!seen && lat < 20) begin
            step();
            lat++;
            if (cpu_clock === 1'b1) seen = 1'b1;
            else cmp_now({tag, ".wait"});
        end
        chk({tag, ".latency_ok"}, 16'(seen && lat >= lo && lat <= hi), 16'd1);
    endtask

    // n full periods in run mode; halt is requested after cut samples of the last period.
    task automatic run_periods(input logic [1:0] sel, input int n, input int cut, input string tag);
        int l = plen(sel);
        mode     = 2'b01;
        rate_sel = sel;
        for (int p = 0; p < n; p++) begin
            push_period(l, l);
            if (p == n - 1) begin
                play(cut, tag);
                mode = 2'b00;
                play(2 * l - cut, tag);
            end else begin
                play(2 * l, tag);
            end
        end
        play(3, {tag, ".idle"});
    endtask

    task automatic do_step(input logic [1:0] sel);
        int l = plen(sel);
        mode     = 2'b10;
        rate_sel = sel;
        press(10);
        wait_rise("step", 6, 9);
        push_period(l, l);
        cmp_now("step");
        play(2 * l - 1, "step");
        play(10, "step.idle");
    endtask

    task automatic do_burst(input logic [1:0] sel, input logic [7:0] len);
        int l = plen(sel);
        mode      = 2'b11;
        rate_sel  = sel;
        burst_len = len;
        press(10);
        wait_rise("burst", 6, 9);
        repeat (int'(len)) push_period(l, l);
        cmp_now("burst");
        burst_len = 8'($urandom_range(0, 255));
        play(2 * l * int'(len) - 1, "burst");
        play(10, "burst.idle");
    endtask

    initial begin
        play(3, "reset");
        rst_n = 1'b1;
        play(3, "idle");

        run_periods(2'd0, 3, 4, "run0");
        chk("run0.final_edges", edge_count, 16'd3);

        repeat (3) begin
            logic [1:0] s;
            int n;
            s = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 4);
            run_periods(s, n, $urandom_range(1, 2 * plen(s)), "runr");
        end

        do_step(2'd0);

        press(2);
        play(20, "glitch");

        do_burst(2'd1, 8'd3);
        repeat (2) do_burst(2'($urandom_range(0, 3)), 8'($urandom_range(1, 5)));

        mode      = 2'b11;
        burst_len = 8'd0;
        press(10);
        play(20, "burst0");

        mode     = 2'b01;
        rate_sel = 2'd0;
        push_period(4, 2);
        play(2, "ratechg");
        rate_sel = 2'd1;
        play(4, "ratechg");
        push_period(2, 2);
        play(4, "ratechg");
        push_period(2, 2);
        play(2, "ratechg");
        mode = 2'b00;
        play(2, "ratechg");
        play(3, "ratechg.idle");

        run_periods(2'd0, 1, 2, "halt");

        mode     = 2'b01;
        rate_sel = 2'd0;
        push_period(4, 4);
        play(2, "rstmid");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        prev_hi     = 1'b0;
        model_edges = 16'd0;
        chk("rstmid.clk",   16'(cpu_clock), 16'd0);
        chk("rstmid.busy",  16'(busy),      16'd0);
        chk("rstmid.edges", edge_count,     16'd0);
        play(2, "rstmid.hold");
        rst_n = 1'b1;
        run_periods(2'd0, 2, 8, "rstrun");

        force dut.edge_count_q = 16'hFFFE;
        step();
        release dut.edge_count_q;
        model_edges = 16'hFFFE;
        cmp_now("wrap.pre");
        run_periods(2'd3, 2, 2, "wrap");
        chk("wrap.zero", edge_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
